// File: rtl/rv_iter_divider_pkg.sv
// Shared types and op-code helpers for the RV32M iterative divider.
package rv_iter_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/rv_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module rv_div_step
  import rv_iter_divider_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN:0]   rem_nxt,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // Extra top bit of diff acts as the borrow of the trial subtraction.
  always_comb begin
    shifted = {rem, dvd_bit};
    diff    = shifted - {2'b00, dvs};
    q_bit   = ~diff[XLEN+1];
    rem_nxt = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/rv_iter_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (radix-2 restoring) with RISC-V special cases.
// Optional last-operation result cache enabled by defining RV_DIV_LAST_OP_CACHE_EN.
module rv_iter_divider
  import rv_iter_divider_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opr_1,
  input  logic [XLEN-1:0] opr_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t state, state_nxt;
  logic accept, short_path;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dvd, dvs;
  logic [XLEN:0]    rem, rem_nxt;
  logic             q_bit, q_neg, r_neg, sel_rem;

  logic             sgn, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0]  abs_a, abs_b, sp_q, sp_r, fix_q, fix_r;
  logic             cache_hit;
  logic [XLEN-1:0]  cache_q, cache_r;

  rv_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem),
    .dvd_bit (dvd[XLEN-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  // Operand conditioning and short-path result selection at accept time.
  always_comb begin
    sgn        = op_is_signed(op);
    a_neg      = sgn & opr_1[XLEN-1];
    b_neg      = sgn & opr_2[XLEN-1];
    abs_a      = a_neg ? -opr_1 : opr_1;
    abs_b      = b_neg ? -opr_2 : opr_2;
    div_zero   = (opr_2 == '0);
    ovf        = sgn && (opr_1 == MIN_NEG) && (opr_2 == '1);
    sp_q       = cache_q;
    sp_r       = cache_r;
    if (div_zero) begin
      sp_q = '1;
      sp_r = opr_1;
    end else if (ovf) begin
      sp_q = opr_1;
      sp_r = '0;
    end
    short_path = div_zero | ovf | cache_hit;
    fix_q      = q_neg ? -dvd : dvd;
    fix_r      = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  end

  // Next-state logic; flush forces IDLE and blocks accept/consume.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          accept    = 1'b1;
          state_nxt = short_path ? ST_DONE : ST_CALC;
        end
        ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: if (out_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
    end
  end

  // Datapath: operand latch, iteration, sign fix-up, result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      sel_rem <= 1'b0;
      out     <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(XLEN - 1);
      dvd     <= abs_a;
      dvs     <= abs_b;
      rem     <= '0;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
      sel_rem <= op_is_rem(op);
      if (short_path) out <= op_is_rem(op) ? sp_r : sp_q;
    end else if (!flush && state == ST_CALC) begin
      cnt <= cnt - 1'b1;
      dvd <= {dvd[XLEN-2:0], q_bit};
      rem <= rem_nxt;
    end else if (!flush && state == ST_FIX) begin
      out <= sel_rem ? fix_r : fix_q;
    end
  end

`ifdef RV_DIV_LAST_OP_CACHE_EN
  logic            c_vld, c_u, p_u;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r, p_a, p_b;

  // Remember the last fully computed op; rst invalidates, flush never writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_vld <= 1'b0;
      c_u   <= 1'b0;
      c_a   <= '0;
      c_b   <= '0;
      c_q   <= '0;
      c_r   <= '0;
      p_u   <= 1'b0;
      p_a   <= '0;
      p_b   <= '0;
    end else begin
      if (accept) begin
        p_a <= opr_1;
        p_b <= opr_2;
        p_u <= op[0];
      end
      if (!flush && state == ST_FIX) begin
        c_vld <= 1'b1;
        c_a   <= p_a;
        c_b   <= p_b;
        c_u   <= p_u;
        c_q   <= fix_q;
        c_r   <= fix_r;
      end
    end
  end

  assign cache_hit = c_vld && (opr_1 == c_a) && (opr_2 == c_b) && (op[0] == c_u);
  assign cache_q   = c_q;
  assign cache_r   = c_r;
`else
  assign cache_hit = 1'b0;
  assign cache_q   = '0;
  assign cache_r   = '0;
`endif

endmodule
